// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: counts in-flight writes per architectural
// register and stalls decode on RAW hazards or counter saturation.
module id_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [$clog2(NREG)-1:0]  id_ra_addr,
    input  logic                     id_ra_used,
    input  logic [$clog2(NREG)-1:0]  id_rb_addr,
    input  logic                     id_rb_used,
    input  logic [$clog2(NREG)-1:0]  id_rd_addr,
    input  logic                     id_rd_wr,
    input  logic                     wb_wr_en,
    input  logic [$clog2(NREG)-1:0]  wb_addr,
    output logic                     stall,
    output logic                     issue,
    output logic [NREG-1:0]          busy_vec,
    output logic                     sb_err
);

    localparam int AW = $clog2(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Handshake: decode presents an instruction with id_valid; it is accepted
    // (and leaves decode) only in a cycle where issue = id_valid & ~stall.
    // stall never depends on issue, so there is no combinational loop.

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic [NREG-1:0]  under_vec;

    logic [CNT_W-1:0] ra_cnt;
    logic [CNT_W-1:0] rb_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             dec_ra;
    logic             dec_rb;
    logic             dec_rd;
    logic             haz_a;
    logic             haz_b;
    logic             haz_sat;

    // Commit snoop: a write-back to a nonzero register retires one in-flight write.
    always_comb begin
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            dec_vec[r] = wb_wr_en && (wb_addr == AW'(r));
        end
    end

    // Hazard detection: a source is only blocked by writes that are still
    // outstanding after this cycle's commit, since the register file forwards it.
    always_comb begin
        ra_cnt  = cnt_q[id_ra_addr];
        rb_cnt  = cnt_q[id_rb_addr];
        rd_cnt  = cnt_q[id_rd_addr];
        dec_ra  = dec_vec[id_ra_addr];
        dec_rb  = dec_vec[id_rb_addr];
        dec_rd  = dec_vec[id_rd_addr];
        haz_a   = id_ra_used && (id_ra_addr != '0) && (ra_cnt > CNT_W'(dec_ra));
        haz_b   = id_rb_used && (id_rb_addr != '0) && (rb_cnt > CNT_W'(dec_rb));
        haz_sat = id_rd_wr && (id_rd_addr != '0) && (rd_cnt == CNT_MAX) && !dec_rd;
        stall   = id_valid && (haz_a || haz_b || haz_sat);
        issue   = id_valid && !stall;
    end

    always_comb begin
        inc_vec   = '0;
        under_vec = '0;
        cnt_d[0]  = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = issue && id_rd_wr && (id_rd_addr == AW'(r));
            cnt_d[r]   = cnt_q[r];
            case ({inc_vec[r], dec_vec[r]})
                2'b10: cnt_d[r] = cnt_q[r] + 1'b1;
                2'b01: begin
                    if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
                    else                under_vec[r] = 1'b1;
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            if (|under_vec) sb_err <= 1'b1;
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: reset, RAW stall timing, register zero,
// saturation, simultaneous inc/dec, underflow error and reset recovery.
module tb_id_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_ra_addr;
    logic        id_ra_used;
    logic [4:0]  id_rb_addr;
    logic        id_rb_used;
    logic [4:0]  id_rd_addr;
    logic        id_rd_wr;
    logic        wb_wr_en;
    logic [4:0]  wb_addr;
    logic        stall;
    logic        issue;
    logic [31:0] busy_vec;
    logic        sb_err;

    int n_cmp = 0;
    int n_err = 0;

    id_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_ra_addr (id_ra_addr),
        .id_ra_used (id_ra_used),
        .id_rb_addr (id_rb_addr),
        .id_rb_used (id_rb_used),
        .id_rd_addr (id_rd_addr),
        .id_rd_wr   (id_rd_wr),
        .wb_wr_en   (wb_wr_en),
        .wb_addr    (wb_addr),
        .stall      (stall),
        .issue      (issue),
        .busy_vec   (busy_vec),
        .sb_err     (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] ra, input logic ra_u,
                         input logic [4:0] rb, input logic rb_u,
                         input logic [4:0] rd, input logic rd_w,
                         input logic wb_e, input logic [4:0] wb_a);
        id_valid   = v;
        id_ra_addr = ra;
        id_ra_used = ra_u;
        id_rb_addr = rb;
        id_rb_used = rb_u;
        id_rd_addr = rd;
        id_rd_wr   = rd_w;
        wb_wr_en   = wb_e;
        wb_addr    = wb_a;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Inputs change at posedge+1; outputs are sampled at the following negedge.
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset with random inputs, then release with inputs idle.
        rst = 1'b1;
        idle();
        for (int i = 0; i < 2; i++) begin
            drive($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom_range(0, 1),
                  5'($urandom_range(0, 31)), $urandom_range(0, 1),
                  5'($urandom_range(0, 31)), $urandom_range(0, 1),
                  $urandom_range(0, 1), 5'($urandom_range(0, 31)));
            tick();
        end
        rst = 1'b0;
        idle();
        settle();
        chk("reset_busy", busy_vec, 32'h0);
        chk("reset_err", {31'b0, sb_err}, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_issue", {31'b0, issue}, 32'h0);
        tick();

        // 2. RAW on r3: producer issues, consumer stalls 2 cycles, proceeds at commit.
        drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
        settle();
        chk("raw_prod_issue", {31'b0, issue}, 32'h1);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("raw_busy3", busy_vec, 32'h0000_0008);
        chk("raw_stall1", {31'b0, stall}, 32'h1);
        chk("raw_issue1", {31'b0, issue}, 32'h0);
        tick();
        settle();
        chk("raw_stall2", {31'b0, stall}, 32'h1);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 1, 3);
        settle();
        chk("raw_commit_stall", {31'b0, stall}, 32'h0);
        chk("raw_commit_issue", {31'b0, issue}, 32'h1);
        tick();
        idle();
        settle();
        chk("raw_busy_clear", busy_vec, 32'h0);
        tick();

        // 3. Register zero is never tracked.
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
        settle();
        chk("zero_wr_stall", {31'b0, stall}, 32'h0);
        tick();
        drive(1, 0, 1, 0, 1, 0, 0, 1, 0);
        settle();
        chk("zero_rd_stall", {31'b0, stall}, 32'h0);
        chk("zero_busy", busy_vec, 32'h0);
        tick();
        idle();
        settle();
        chk("zero_wb_err", {31'b0, sb_err}, 32'h0);
        chk("zero_busy2", busy_vec, 32'h0);
        tick();

        // 4. Saturation on r5: three issues fill the counter, fourth stalls.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
            settle();
            chk("sat_fill_issue", {31'b0, issue}, 32'h1);
            tick();
        end
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        settle();
        chk("sat_full_stall", {31'b0, stall}, 32'h1);
        chk("sat_full_issue", {31'b0, issue}, 32'h0);
        chk("sat_busy5", busy_vec, 32'h0000_0020);
        tick();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 5);
        settle();
        chk("sat_commit_stall", {31'b0, stall}, 32'h0);
        chk("sat_commit_issue", {31'b0, issue}, 32'h1);
        tick();
        drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
        settle();
        chk("sat_still_full", {31'b0, stall}, 32'h1);
        tick();
        // Drain: two commits leave r5 busy, the third frees it.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 5);
            tick();
            idle();
            settle();
            chk("sat_drain_busy", busy_vec, (i < 2) ? 32'h0000_0020 : 32'h0);
        end
        chk("sat_err", {31'b0, sb_err}, 32'h0);
        tick();

        // 5. Simultaneous inc/dec on r7 keeps the count at 1.
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 7);
        settle();
        chk("simul_issue", {31'b0, issue}, 32'h1);
        tick();
        drive(1, 7, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("simul_unused_ra", {31'b0, stall}, 32'h0);
        chk("simul_busy7", busy_vec, 32'h0000_0080);
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0);
        settle();
        chk("simul_rb_stall", {31'b0, stall}, 32'h1);
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 1, 7);
        settle();
        chk("simul_commit_stall", {31'b0, stall}, 32'h0);
        tick();
        idle();
        settle();
        chk("simul_busy_clear", busy_vec, 32'h0);
        chk("simul_err", {31'b0, sb_err}, 32'h0);
        tick();

        // 6. Underflow on r9, sticky error, then reset discards pending r12.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        drive(1, 0, 0, 0, 0, 12, 1, 0, 0);
        tick();
        idle();
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("under_err_held", {31'b0, sb_err}, 32'h1);
            tick();
        end
        settle();
        chk("under_busy12", busy_vec, 32'h0000_1000);
        tick();
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 12, 1, 1, 9);
        tick();
        rst = 1'b0;
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("recover_err", {31'b0, sb_err}, 32'h0);
        chk("recover_busy", busy_vec, 32'h0);
        chk("recover_stall", {31'b0, stall}, 32'h0);
        chk("recover_issue", {31'b0, issue}, 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Decode-stage register scoreboard for the 64-bit in-order pipeline. It tracks in-flight writes to each of the 32 architectural registers and stalls decode when an instruction would read a register whose newest value has not yet reached the register file. It sits between the decode stage, which issues instructions, and the register file write port, whose commit signals it snoops. Same-cycle writeback is not a hazard because the register file forwards its write data to its read ports internally.

## Interface
- NREG, 32: number of architectural registers; register 0 is hardwired zero and never tracked.
- CNT_W, 2: width of each per-register in-flight counter; MAX = 2^CNT_W - 1 outstanding writes per register.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_ra_addr  in  5  source A register address
- id_ra_used  in  1  instruction reads rA
- id_rb_addr  in  5  source B register address
- id_rb_used  in  1  instruction reads rB
- id_rd_addr  in  5  destination register address
- id_rd_wr  in  1  instruction writes rD (any ppp mode)
- wb_wr_en  in  1  register-file write commit; the same net as the register file wr_en
- wb_addr  in  5  committed destination; the same net as the register file in_addr, low 5 bits
- stall  out  1  combinational; hold decode this cycle
- issue  out  1  combinational; id_valid & ~stall
- busy_vec  out  NREG  bit r = (cnt[r] != 0); bit 0 is always 0
- sb_err  out  1  sticky underflow error

## Operation
- State: cnt[r], a CNT_W-bit counter per register, r = 1..NREG-1. There is no cnt[0]; address 0 never sets, clears or stalls.
- inc[r] = issue & id_rd_wr & (id_rd_addr == r) & (r != 0).
- dec[r] = wb_wr_en & (wb_addr == r) & (r != 0).
- Counter update:
  - inc only: cnt + 1.
  - dec only, cnt != 0: cnt - 1.
  - inc and dec together: cnt unchanged.
  - dec with cnt == 0: cnt stays 0 and sb_err is set.
- RAW hazard, for source X in {A, B}: haz_X = X_used & (addr_X != 0) & (cnt[addr_X] > dec[addr_X]).
  - A last outstanding write that commits this cycle is not a hazard, because the register file forwards it.
- Saturation: haz_sat = id_rd_wr & (id_rd_addr != 0) & (cnt[id_rd_addr] == MAX) & ~dec[id_rd_addr].
  - This prevents counter overflow. Overflow is unreachable by construction.
- stall = id_valid & (haz_A | haz_B | haz_sat).
- Writes commit in program order, so WAW needs no check beyond counting.
- Partial-write (ppp != 000) destinations are counted identically to full writes.
- Issued instructions are never squashed; branches resolve in decode. Every inc is therefore eventually matched by exactly one dec.
- sb_err stays high until rst.

## Timing
- rst is sampled at posedge and overrides all other inputs. On the edge after rst is asserted:
  - all cnt = 0, busy_vec = 0, sb_err = 0;
  - stall and issue then follow their equations, so stall = 0 and issue = id_valid.
- Asserting rst mid-operation discards all pending state. The pipeline is flushed by the same rst.
- stall and issue are combinational from the current inputs and registered counts. There are no internal combinational loops: issue depends on stall, and stall does not depend on issue.
- Counters, busy_vec and sb_err update at posedge. busy_vec reflects a new issue one cycle after issue is high.
- A read of register r issued in the same cycle as the final wb commit to r proceeds with zero bubbles.
- A dependent instruction stalls for exactly the cycles until the producer's commit cycle, inclusive of no extra bubble.

## Test plan
1. Reset: hold rst for 2 cycles with random inputs, then release with all inputs 0 -> busy_vec = 0, sb_err = 0, stall = 0.
2. RAW: issue rd=3, then present ra=3 used; commit wb_addr=3 three cycles later -> stall = 1 for 2 cycles and 0 in the commit cycle (issue = 1); busy_vec[3] is 0 after the following edge.
3. Zero register: issue rd=0, then read ra=0 and rb=0 -> stall always 0, busy_vec stays 0; a wb commit to address 0 does not set sb_err.
4. Saturation (CNT_W=2): issue rd=5 three times, fourth attempt -> stall = 1 and cnt[5] = 3. Repeat with wb_addr=5 committing in the fourth-attempt cycle -> issue = 1 and cnt[5] stays 3.
5. Simultaneous set/clear: cnt[7] = 1, issue rd=7 with wb_addr=7 in the same cycle -> cnt[7] = 1 next cycle; a following ra=7 read stalls until the second commit.
6. Underflow and recovery: wb_wr_en with wb_addr=9 while cnt[9] = 0 -> sb_err = 1 next cycle and held for 10 cycles. Assert rst -> sb_err = 0 and all counters 0.
